// File: rtl/dyn_phase_seq_if.sv
// Move-command handshake into the PLL phase sequencer; a command transfers on CMD_VALID & CMD_READY.
// CMD_TARGET is an absolute signed position in PLL phase steps.
interface dyn_phase_seq_if #(
  parameter int POS_W = 10
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [2:0]       CMD_CH;
  logic [POS_W-1:0] CMD_TARGET;

  modport master (output CMD_VALID, CMD_CH, CMD_TARGET, input CMD_READY);
  modport slave  (input CMD_VALID, CMD_CH, CMD_TARGET, output CMD_READY);
endinterface

// File: rtl/dyn_phase_seq.sv
// Walks one PLL output counter to an absolute phase position, one PHASESTEP at a time, tracking POS per channel.
// Each step takes ~2 strobe cycles plus the PHASEDONE round trip; commands are only accepted while idle.
module dyn_phase_seq #(
  parameter int         NUM_CH      = 5,
  parameter int         POS_W       = 10,
  parameter logic [3:0] CNTSEL_BASE = 4'h2,
  parameter int         TMO_CYC     = 1024
) (
  input  logic                    CLK50M,
  input  logic                    RESET,
  dyn_phase_seq_if.slave          cmd,
  input  logic                    ABORT,
  input  logic                    PHASEDONE,
  output logic [3:0]              PHASECOUNTERSELECT,
  output logic                    PHASEUPDOWN,
  output logic                    PHASESTEP,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR,
  output logic [NUM_CH*POS_W-1:0] POS
);

  typedef enum logic [2:0] {IDLE, SETUP, STEP, WAIT_LO, WAIT_HI} state_t;
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  state_t                 state, state_nxt;
  logic                   pd_meta, pd_sync;
  logic [POS_W-1:0]       pos_r [NUM_CH];
  logic [2:0]             ch;
  logic                   dir;
  logic                   abort_seen;
  logic                   step_cnt;
  logic [POS_W:0]         remaining;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [POS_W-1:0]       cur_pos;
  logic signed [POS_W:0]  delta;
  logic                   ch_ok, accept, zero_move, delta_pos;
  logic                   tmo_hit, timeout, step_ok, finish;

  always_comb begin
    cur_pos = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (int'(cmd.CMD_CH) == i) cur_pos = pos_r[i];
  end

  // One extra bit so the difference of two signed POS_W values cannot overflow.
  assign delta     = $signed({cmd.CMD_TARGET[POS_W-1], cmd.CMD_TARGET}) - $signed({cur_pos[POS_W-1], cur_pos});
  assign delta_pos = !delta[POS_W] && (delta != '0);
  assign zero_move = (delta == '0);
  assign ch_ok     = int'(cmd.CMD_CH) < NUM_CH;

  assign cmd.CMD_READY = (state == IDLE) && !RESET;
  assign accept        = cmd.CMD_VALID && cmd.CMD_READY && ch_ok;
  assign BUSY          = (state != IDLE) && !RESET;
  assign PHASESTEP     = (state == STEP);

  assign tmo_hit = (tmo_cnt == TMO_W'(TMO_CYC - 1));
  assign timeout = tmo_hit && (((state == WAIT_LO) && pd_sync) || ((state == WAIT_HI) && !pd_sync));
  assign step_ok = (state == WAIT_HI) && pd_sync;
  assign finish  = (remaining == (POS_W+1)'(1)) || abort_seen || ABORT;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !zero_move) state_nxt = SETUP;
      SETUP:   state_nxt = STEP;
      STEP:    if (step_cnt) state_nxt = WAIT_LO;
      WAIT_LO: if (!pd_sync) state_nxt = WAIT_HI;
               else if (tmo_hit) state_nxt = IDLE;
      WAIT_HI: if (pd_sync) state_nxt = finish ? IDLE : SETUP;
               else if (tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK50M) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      pd_meta            <= 1'b0;
      pd_sync            <= 1'b0;
      ch                 <= '0;
      dir                <= 1'b0;
      abort_seen         <= 1'b0;
      step_cnt           <= 1'b0;
      remaining          <= '0;
      tmo_cnt            <= '0;
      PHASECOUNTERSELECT <= '0;
      PHASEUPDOWN        <= 1'b0;
      DONE               <= 1'b0;
      ERR                <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) pos_r[i] <= '0;
    end else begin
      pd_meta  <= PHASEDONE;
      pd_sync  <= pd_meta;
      DONE     <= 1'b0;
      step_cnt <= (state == STEP) ? ~step_cnt : 1'b0;
      // Leaving STEP zeroes the counter, so each WAIT_LO starts a fresh budget.
      tmo_cnt  <= ((state == WAIT_LO) || (state == WAIT_HI)) ? tmo_cnt + 1'b1 : '0;

      if ((state != IDLE) && ABORT) abort_seen <= 1'b1;

      if (accept) begin
        ch                 <= cmd.CMD_CH;
        dir                <= delta_pos;
        remaining          <= delta[POS_W] ? unsigned'(-delta) : unsigned'(delta);
        abort_seen         <= 1'b0;
        ERR                <= 1'b0;
        PHASECOUNTERSELECT <= CNTSEL_BASE + {1'b0, cmd.CMD_CH};
        PHASEUPDOWN        <= delta_pos;
        if (zero_move) DONE <= 1'b1;
      end

      if (step_ok) begin
        for (int i = 0; i < NUM_CH; i++)
          if (int'(ch) == i) pos_r[i] <= dir ? pos_r[i] + 1'b1 : pos_r[i] - 1'b1;
        remaining <= remaining - 1'b1;
        if (finish) DONE <= 1'b1;
      end else if (timeout) begin
        ERR <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
    assign POS[g*POS_W +: POS_W] = pos_r[g];
  end

endmodule

// File: doc/dyn_phase_seq.md
DYN_PHASE_SEQ -- requirements
Module: dyn_phase_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, meaning number of PLL output counters controlled (1..5).
REQ-002 SHALL have parameter POS_W, default 10, meaning signed phase-position width per channel, in PLL steps.
REQ-003 SHALL have parameter CNTSEL_BASE, default 4'h2, meaning the PHASECOUNTERSELECT code of channel 0 (C0).
REQ-004 SHALL have parameter TMO_CYC, default 1024, meaning the PHASEDONE timeout per step, in clock cycles.
REQ-005 SHALL use one clock and a synchronous, active-high reset; CLK50M and RESET are the clock and reset ports, and the polarity and synchronicity are fixed.
REQ-006 SHALL have port CLK50M  in  1  clock; also PLL scan clock.
REQ-007 SHALL have port RESET  in  1  synchronous active-high reset.
REQ-008 SHALL have port CMD_VALID  in  1  move request.
REQ-009 SHALL have port CMD_READY  out  1  block able to accept a move.
REQ-010 SHALL have port CMD_CH  in  3  target channel index.
REQ-011 SHALL have port CMD_TARGET  in  POS_W  absolute signed target position.
REQ-012 SHALL have port ABORT  in  1  stop after the current step.
REQ-013 SHALL have port PHASEDONE  in  1  PLL phase-done, asynchronous.
REQ-014 SHALL have port PHASECOUNTERSELECT  out  4  PLL counter select.
REQ-015 SHALL have port PHASEUPDOWN  out  1  step direction, 1 = up.
REQ-016 SHALL have port PHASESTEP  out  1  PLL step strobe.
REQ-017 SHALL have port BUSY  out  1  move in progress.
REQ-018 SHALL have port DONE  out  1  one-cycle move-complete pulse.
REQ-019 SHALL have port ERR  out  1  sticky timeout flag.
REQ-020 SHALL have port POS  out  NUM_CH*POS_W  current position per channel, channel 0 in the LSBs.

Function
REQ-021 SHALL synchronise PHASEDONE through 2 flops and act only on the synchronised value.
REQ-022 SHALL assert CMD_READY only in IDLE, and SHALL accept a command on CMD_VALID & CMD_READY.
REQ-023 SHALL ignore commands with CMD_CH >= NUM_CH, leaving state unchanged with no DONE.
REQ-024 SHALL, on accept, latch ch, delta = TARGET - POS[ch] computed in POS_W+1 bits signed, dir = (delta > 0) and remaining = |delta|.
REQ-025 SHALL, when delta = 0, return to IDLE and pulse DONE the cycle after accept, with no PHASESTEP.
REQ-026 SHALL implement FSM IDLE -> SETUP -> STEP -> WAIT_LO -> WAIT_HI -> (SETUP | IDLE).
REQ-027 SHALL, in SETUP (1 cycle), drive PHASECOUNTERSELECT = CNTSEL_BASE + ch and PHASEUPDOWN = dir, held stable until IDLE.
REQ-028 SHALL, in STEP, hold PHASESTEP high for exactly 2 cycles.
REQ-029 SHALL remain in WAIT_LO until synchronised PHASEDONE = 0, then in WAIT_HI until it is 1.
REQ-030 SHALL, on WAIT_HI exit, add or subtract 1 to POS[ch] (wrap modulo 2^POS_W) and decrement remaining.
REQ-031 SHALL, on WAIT_HI exit, go to IDLE and pulse DONE if remaining = 0 or ABORT was seen since accept; otherwise go to SETUP.
REQ-032 SHALL clear the timeout counter on entry to WAIT_LO and run it through WAIT_LO and WAIT_HI.
REQ-033 SHALL, at TMO_CYC, set ERR, go to IDLE, leave POS[ch] unchanged for that step and not pulse DONE.
REQ-034 SHALL have ERR cleared only by RESET or by the next accepted command.
REQ-035 SHALL ignore ABORT in IDLE.
REQ-036 SHALL assert BUSY = (state != IDLE).
REQ-037 SHALL leave other channels' POS unaffected by a move.

Reset
REQ-038 SHALL, while RESET is high, force state IDLE and drive PHASESTEP=0, PHASEUPDOWN=0, PHASECOUNTERSELECT=0, CMD_READY=0, BUSY=0, DONE=0, ERR=0 and all POS=0.
REQ-039 SHALL, on RESET mid-step, drop PHASESTEP within the same clock edge, leave no POS update and raise CMD_READY the first cycle after RESET falls.

Verification
REQ-040 SHALL be verified with: ch1, POS 0, target +3 -> PHASECOUNTERSELECT=4'h3, UPDOWN=1, 3 PHASESTEP pulses of 2 cycles each, POS[1]=3, one DONE pulse.
REQ-041 SHALL be verified with: ch1 then target -2 -> UPDOWN=0, 5 steps, POS[1]=-2 (10'h3FE), DONE once.
REQ-042 SHALL be verified with: target equal to current position -> no PHASESTEP, DONE one cycle after accept.
REQ-043 SHALL be verified with: PHASEDONE held high during step 2 of 4 -> ERR=1 after TMO_CYC, POS advanced by 1 only, no DONE, CMD_READY=1.
REQ-044 SHALL be verified with: ABORT during step 2 of 6 -> exactly 2 steps taken, POS +/-2, DONE pulse.
REQ-045 SHALL be verified with: CMD_VALID while BUSY, and CMD_CH=7 -> both ignored, and RESET during STEP -> all outputs at reset values next cycle.
